// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu_pkg                                            |
// | Description : Shared ALU op codes, instruction opcode/funct3     |
// |               constants, branch kinds and driver FSM states.     |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package alu_pkg;

  // ALU operation codes as seen on the ALU control input
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  // Major opcodes handled by the execute stage
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // Branch kind carried from accept to the result capture
  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_EQ   = 2'd1;
  localparam logic [1:0] BR_NE   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu_op_encoder                                     |
// | Description : Combinational decode of opcode/funct3/funct7b5     |
// |               into ALU op, operand selects and branch kind.      |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module alu_op_encoder
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_op,
  output logic       b_sel_imm,
  output logic       a_zero,
  output logic       shift_mask,
  output logic [1:0] branch_kind,
  output logic       illegal
);

  // Decode table; anything not explicitly listed is flagged illegal
  always_comb begin
    alu_op      = ALU_ADD;
    b_sel_imm   = 1'b0;
    a_zero      = 1'b0;
    shift_mask  = 1'b0;
    branch_kind = BR_NONE;
    illegal     = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          F3_ADD_SUB: alu_op = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_XOR:     alu_op = ALU_XOR;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          F3_SLL: begin
            alu_op     = ALU_SLL;
            shift_mask = 1'b1;
            illegal    = funct7b5;
          end
          F3_SRL_SRA: begin
            // SRA (b5=1) is not supported by this ALU
            alu_op     = ALU_SRL;
            shift_mask = 1'b1;
            illegal    = funct7b5;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_I: begin
        // bit 30 is immediate payload except for shifts
        b_sel_imm = 1'b1;
        case (funct3)
          F3_ADD_SUB: alu_op = ALU_ADD;
          F3_XOR:     alu_op = ALU_XOR;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          F3_SLL: begin
            alu_op     = ALU_SLL;
            shift_mask = 1'b1;
            illegal    = funct7b5;
          end
          F3_SRL_SRA: begin
            alu_op     = ALU_SRL;
            shift_mask = 1'b1;
            illegal    = funct7b5;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        alu_op    = ALU_LUI;
        a_zero    = 1'b1;
        b_sel_imm = 1'b1;
      end
      OP_LOAD, OP_STORE, OP_JALR: begin
        alu_op    = ALU_ADD;
        b_sel_imm = 1'b1;
      end
      OP_BRANCH: begin
        alu_op = ALU_SUB;
        case (funct3)
          F3_BEQ:  branch_kind = BR_EQ;
          F3_BNE:  branch_kind = BR_NE;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule : alu_op_encoder
`default_nettype wire

// File: rtl/alu_op_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu_op_driver                                      |
// | Description : Execute-stage front end: accepts decoded fields,   |
// |               issues one ALU operation, returns the result with  |
// |               zero / branch-taken / illegal flags.               |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7b5_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [3:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_branch_taken_o,
  output logic              rsp_illegal_o
);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        enc_op;
  logic              enc_b_imm;
  logic              enc_a_zero;
  logic              enc_shift;
  logic [1:0]        enc_branch;
  logic              enc_illegal;
  logic              accept;
  logic [DATA_W-1:0] b_src;
  logic [DATA_W-1:0] b_operand;
  logic [1:0]        branch_kind;

  alu_op_encoder u_encoder (
    .opcode      (opcode_i),
    .funct3      (funct3_i),
    .funct7b5    (funct7b5_i),
    .alu_op      (enc_op),
    .b_sel_imm   (enc_b_imm),
    .a_zero      (enc_a_zero),
    .shift_mask  (enc_shift),
    .branch_kind (enc_branch),
    .illegal     (enc_illegal)
  );

  assign accept    = req_valid_i && (state == ST_IDLE);
  assign b_src     = enc_b_imm ? imm_i : rs2_i;
  // Shifts only see the low shift-amount bits of the B source
  assign b_operand = enc_shift ? {{(DATA_W-SHAMT_W){1'b0}}, b_src[SHAMT_W-1:0]} : b_src;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; illegal requests skip the ALU cycle
  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = enc_illegal ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU operand registers, loaded only on a legal accept and held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op_o    <= ALU_ADD;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      branch_kind <= BR_NONE;
    end else if (accept && !enc_illegal) begin
      alu_op_o    <= enc_op;
      alu_a_o     <= enc_a_zero ? '0 : rs1_i;
      alu_b_o     <= b_operand;
      branch_kind <= enc_branch;
    end
  end

  // Response registers: filled at ISSUE end or on an illegal accept, held through RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result_o       <= '0;
      rsp_zero_o         <= 1'b0;
      rsp_branch_taken_o <= 1'b0;
      rsp_illegal_o      <= 1'b0;
    end else if (accept && enc_illegal) begin
      rsp_result_o       <= '0;
      rsp_zero_o         <= 1'b0;
      rsp_branch_taken_o <= 1'b0;
      rsp_illegal_o      <= 1'b1;
    end else if (state == ST_ISSUE) begin
      rsp_result_o       <= alu_result_i;
      rsp_zero_o         <= alu_zero_i;
      rsp_branch_taken_o <= ((branch_kind == BR_EQ) && alu_zero_i) ||
                            ((branch_kind == BR_NE) && !alu_zero_i);
      rsp_illegal_o      <= 1'b0;
    end
  end

endmodule : alu_op_driver
`default_nettype wire

// File: tb/tb_alu_op_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_alu_op_driver                                   |
// | Description : Directed self-checking bench for alu_op_driver     |
// |               with a behavioural ALU attached.                   |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_alu_op_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic        funct7b5_i;
  logic [31:0] rs1_i, rs2_i, imm_i;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_driver dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .opcode_i           (opcode_i),
    .funct3_i           (funct3_i),
    .funct7b5_i         (funct7b5_i),
    .rs1_i              (rs1_i),
    .rs2_i              (rs2_i),
    .imm_i              (imm_i),
    .alu_op_o           (alu_op_o),
    .alu_a_o            (alu_a_o),
    .alu_b_o            (alu_b_o),
    .alu_result_i       (alu_result_i),
    .alu_zero_i         (alu_zero_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_result_o       (rsp_result_o),
    .rsp_zero_o         (rsp_zero_o),
    .rsp_branch_taken_o (rsp_branch_taken_o),
    .rsp_illegal_o      (rsp_illegal_o)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU
  always_comb begin
    alu_result_i = 32'h0;
    case (alu_op_o)
      4'b0000: alu_result_i = alu_a_o + alu_b_o;
      4'b0001: alu_result_i = alu_a_o - alu_b_o;
      4'b0010: alu_result_i = alu_a_o ^ alu_b_o;
      4'b0011: alu_result_i = alu_a_o | alu_b_o;
      4'b0100: alu_result_i = alu_a_o & alu_b_o;
      4'b0101: alu_result_i = alu_a_o << alu_b_o[4:0];
      4'b0111: alu_result_i = alu_a_o >> alu_b_o[4:0];
      4'b1001: alu_result_i = alu_b_o << 12;
      default: alu_result_i = 32'h0;
    endcase
    alu_zero_i = (alu_result_i == 32'h0);
  end

  // Present one request for exactly one accept edge; returns #1 after that edge
  task automatic send_req(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    opcode_i = op; funct3_i = f3; funct7b5_i = b5;
    rs1_i = a; rs2_i = b; imm_i = im;
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  // Pulse rsp_ready_i for one edge
  task automatic release_rsp();
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL reset_hs: got ready/valid=%b expected 10", {req_ready_o, rsp_valid_o});
    end
    n_checks++;
    if ({alu_op_o, alu_a_o, alu_b_o} !== 68'h0) begin
      n_fail++; $display("FAIL reset_alu: got op=%h a=%h b=%h expected zeros", alu_op_o, alu_a_o, alu_b_o);
    end
    n_checks++;
    if ({rsp_result_o, rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o} !== 35'h0) begin
      n_fail++; $display("FAIL reset_rsp: got res=%h z=%b t=%b i=%b expected zeros",
                         rsp_result_o, rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o);
    end
  endtask

  task automatic test_sub();
    send_req(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd10, 32'h0);
    n_checks++;
    if ({alu_op_o, alu_a_o, alu_b_o, rsp_valid_o, req_ready_o} !== {4'b0001, 32'd10, 32'd10, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_issue: got op=%b a=%h b=%h v=%b r=%b expected 0001/a/a/0/0",
                         alu_op_o, alu_a_o, alu_b_o, rsp_valid_o, req_ready_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o} !== {1'b1, 32'h0, 3'b100}) begin
      n_fail++; $display("FAIL sub_rsp: got v=%b res=%h z=%b t=%b i=%b expected 1/0/1/0/0",
                         rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o);
    end
    release_rsp();
    n_checks++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL sub_release: got valid/ready=%b expected 01", {rsp_valid_o, req_ready_o});
    end
  endtask

  task automatic test_branch();
    // BNE 5 vs 7
    send_req(7'b1100011, 3'b001, 1'b0, 32'd5, 32'd7, 32'h0000_0010);
    n_checks++;
    if ({alu_op_o, alu_b_o} !== {4'b0001, 32'd7}) begin
      n_fail++; $display("FAIL bne_issue: got op=%b b=%h expected 0001/7", alu_op_o, alu_b_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o} !== {1'b1, 32'hFFFF_FFFE, 3'b010}) begin
      n_fail++; $display("FAIL bne_rsp: got v=%b res=%h z=%b t=%b i=%b expected 1/fffffffe/0/1/0",
                         rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o);
    end
    release_rsp();
    // BEQ 5 vs 7: not taken
    send_req(7'b1100011, 3'b000, 1'b0, 32'd5, 32'd7, 32'h0000_0010);
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o} !== {1'b1, 32'hFFFF_FFFE, 3'b000}) begin
      n_fail++; $display("FAIL beq_ne_rsp: got v=%b res=%h z=%b t=%b expected 1/fffffffe/0/0",
                         rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_branch_taken_o);
    end
    release_rsp();
    // BEQ 9 vs 9: taken
    send_req(7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_zero_o, rsp_branch_taken_o} !== 2'b11) begin
      n_fail++; $display("FAIL beq_eq_rsp: got z/t=%b expected 11", {rsp_zero_o, rsp_branch_taken_o});
    end
    release_rsp();
  endtask

  task automatic test_shift_lui();
    // SLL R-type: only rs2[4:0] reaches the ALU
    send_req(7'b0110011, 3'b001, 1'b0, 32'd1, 32'd33, 32'h0);
    n_checks++;
    if ({alu_op_o, alu_b_o} !== {4'b0101, 32'd1}) begin
      n_fail++; $display("FAIL sll_issue: got op=%b b=%h expected 0101/1", alu_op_o, alu_b_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_result_o !== 32'd2) begin
      n_fail++; $display("FAIL sll_rsp: got %h expected 2", rsp_result_o);
    end
    release_rsp();
    // SRLI with immediate upper bits set: shift by 3
    send_req(7'b0010011, 3'b101, 1'b0, 32'h80, 32'hFFFF, 32'h0000_0FE3);
    n_checks++;
    if ({alu_op_o, alu_b_o} !== {4'b0111, 32'd3}) begin
      n_fail++; $display("FAIL srli_issue: got op=%b b=%h expected 0111/3", alu_op_o, alu_b_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_result_o !== 32'h10) begin
      n_fail++; $display("FAIL srli_rsp: got %h expected 10", rsp_result_o);
    end
    release_rsp();
    // ADDI with negative immediate
    send_req(7'b0010011, 3'b000, 1'b1, 32'd100, 32'd5, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    n_checks++;
    if (rsp_result_o !== 32'd99) begin
      n_fail++; $display("FAIL addi_rsp: got %h expected 63", rsp_result_o);
    end
    release_rsp();
    // Store address: rs1 + imm
    send_req(7'b0100011, 3'b010, 1'b0, 32'h1000, 32'hAAAA, 32'd8);
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_result_o, rsp_illegal_o} !== {32'h1008, 1'b0}) begin
      n_fail++; $display("FAIL store_rsp: got res=%h i=%b expected 1008/0", rsp_result_o, rsp_illegal_o);
    end
    release_rsp();
    // LUI: A forced to zero
    send_req(7'b0110111, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h1, 32'h0001_2345);
    n_checks++;
    if ({alu_op_o, alu_a_o, alu_b_o} !== {4'b1001, 32'h0, 32'h0001_2345}) begin
      n_fail++; $display("FAIL lui_issue: got op=%b a=%h b=%h expected 1001/0/12345", alu_op_o, alu_a_o, alu_b_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_result_o !== 32'h1234_5000) begin
      n_fail++; $display("FAIL lui_rsp: got %h expected 12345000", rsp_result_o);
    end
    release_rsp();
  endtask

  task automatic test_illegal();
    // SRAI, SLT, BLT, unknown opcode, SRA
    logic [6:0] ops [5] = '{7'b0010011, 7'b0110011, 7'b1100011, 7'b1111111, 7'b0110011};
    logic [2:0] f3s [5] = '{3'b101, 3'b010, 3'b100, 3'b000, 3'b101};
    logic       b5s [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      send_req(ops[k], f3s[k], b5s[k], 32'h55, 32'h66, 32'h77);
      n_checks++;
      if ({rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o} !== {1'b1, 32'h0, 3'b001}) begin
        n_fail++; $display("FAIL illegal_rsp[%0d]: got v=%b res=%h z=%b t=%b i=%b expected 1/0/0/0/1", k,
                           rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_branch_taken_o, rsp_illegal_o);
      end
      // ALU operands still hold the earlier LUI
      n_checks++;
      if ({alu_op_o, alu_a_o, alu_b_o} !== {4'b1001, 32'h0, 32'h0001_2345}) begin
        n_fail++; $display("FAIL illegal_noissue[%0d]: got op=%b a=%h b=%h expected 1001/0/12345", k,
                           alu_op_o, alu_a_o, alu_b_o);
      end
      release_rsp();
    end
  endtask

  task automatic test_backpressure();
    send_req(7'b0110011, 3'b100, 1'b0, 32'hF0, 32'hFF, 32'h0);
    @(posedge clk); #1;
    // A competing request must be ignored while the response waits
    opcode_i = 7'b0110011; funct3_i = 3'b111; funct7b5_i = 1'b0;
    rs1_i = 32'hF0; rs2_i = 32'hFF; imm_i = 32'h0;
    req_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({rsp_valid_o, req_ready_o, rsp_result_o, rsp_illegal_o, alu_op_o} !== {2'b10, 32'h0F, 1'b0, 4'b0010}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b r=%b res=%h i=%b op=%b expected 1/0/0f/0/0010", c,
                           rsp_valid_o, req_ready_o, rsp_result_o, rsp_illegal_o, alu_op_o);
      end
      @(posedge clk); #1;
    end
    release_rsp();
    n_checks++;
    if ({rsp_valid_o, req_ready_o, alu_op_o} !== {2'b01, 4'b0010}) begin
      n_fail++; $display("FAIL bp_idle: got v=%b r=%b op=%b expected 0/1/0010", rsp_valid_o, req_ready_o, alu_op_o);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n_checks++;
    if ({req_ready_o, alu_op_o} !== {1'b0, 4'b0100}) begin
      n_fail++; $display("FAIL bp_next_accept: got r=%b op=%b expected 0/0100", req_ready_o, alu_op_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid_o, rsp_result_o} !== {1'b1, 32'hF0}) begin
      n_fail++; $display("FAIL bp_next_rsp: got v=%b res=%h expected 1/f0", rsp_valid_o, rsp_result_o);
    end
    release_rsp();
  endtask

  task automatic test_reset_mid();
    send_req(7'b0110011, 3'b000, 1'b1, 32'd9, 32'd1, 32'h0);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready_o, rsp_valid_o, alu_op_o, alu_a_o, alu_b_o} !== {2'b10, 68'h0}) begin
      n_fail++; $display("FAIL midreset_async: got r=%b v=%b op=%b a=%h b=%h expected 1/0/zeros",
                         req_ready_o, rsp_valid_o, alu_op_o, alu_a_o, alu_b_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({rsp_valid_o, req_ready_o, rsp_result_o} !== {2'b01, 32'h0}) begin
        n_fail++; $display("FAIL midreset_stale[%0d]: got v=%b r=%b res=%h expected 0/1/0", c,
                           rsp_valid_o, req_ready_o, rsp_result_o);
      end
      @(posedge clk); #1;
    end
    send_req(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd4, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_illegal_o} !== {1'b1, 32'd7, 2'b00}) begin
      n_fail++; $display("FAIL midreset_add: got v=%b res=%h z=%b i=%b expected 1/7/0/0",
                         rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_illegal_o);
    end
    release_rsp();
  endtask

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    opcode_i = '0; funct3_i = '0; funct7b5_i = 1'b0;
    rs1_i = '0; rs2_i = '0; imm_i = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_sub();
    test_branch();
    test_shift_lui();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_op_driver
`default_nettype wire
